slt_serial_cmp: RTL and testbench

//  Multi-cycle signed set-less-than unit for WIDTH-bit operands.
//  - Issues operands to a 4-bit subtract slice, LSB nibble first: x + ~y + 1 with carry chained between cycles.
//  - Produces a corrected SLT flag plus the signed-overflow flag for the ALU result mux.
//  - Sits between the operand register stage and the ALU result mux. Valid/ready on both sides.

---
 rtl/slt_serial_cmp.sv | 217 +++++++++++++++++++++
 tb/tb_slt_serial_cmp.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/slt_serial_cmp.sv
`default_nettype none
// ============================================================================
// Module      : slt_serial_cmp
// Description : Multi-cycle set-less-than unit. The operands are subtracted
//               four bits per cycle, least-significant nibble first, as
//               x + ~y + 1 with the carry chained between cycles. The result
//               is a corrected signed less-than flag plus the signed-overflow
//               flag of x - y. Valid/ready handshake on input and output.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      operand width, multiple of 4 (NSLICE = WIDTH/4 slice cycles)
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid          in_ready   unit can accept a pair
//   x, y       operands, two's complement
//   out_valid  result valid                out_ready  consumer takes result
//   set        x < y                       overflow   signed overflow of x - y
//   busy       unit is in RUN or DONE
//   uns        (SLT_UNSIGNED_EN only) 1 = unsigned compare, sampled on accept
// Configuration
//   SLT_UNSIGNED_EN  when defined, adds the uns port and the unsigned mode
// Timing
//   Accept on edge E0, slices processed on E1..E(NSLICE), out_valid rises on
//   E(NSLICE+1) and holds until out_ready is seen.
// ============================================================================
module slt_serial_cmp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             set,
  output logic             overflow,
  output logic             busy
`ifdef SLT_UNSIGNED_EN
  ,
  input  logic             uns
`endif
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           state_q,     state_d;
  logic [IDXW-1:0]  idx_q,       idx_d;
  logic             carry_q,     carry_d;
  logic [WIDTH-1:0] xa_q,        xa_d;
  logic [WIDTH-1:0] yb_q,        yb_d;
  logic             msb_q,       msb_d;
  logic             ovf_q,       ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             set_q,       set_d;
  logic             overflow_q,  overflow_d;
`ifdef SLT_UNSIGNED_EN
  logic             uns_q,       uns_d;
`endif

  // --------------------------------------------------------------------------
  // 4-bit subtract slice on the nibble selected by idx_q
  // --------------------------------------------------------------------------
  logic [3:0] x_nib;
  logic [3:0] y_nib;
  logic [4:0] sum5;
  logic [3:0] low4;
  logic       c_into_3;
  logic       c_out;

  always_comb begin
    x_nib    = xa_q[idx_q*4 +: 4];
    y_nib    = yb_q[idx_q*4 +: 4];
    sum5     = {1'b0, x_nib} + {1'b0, y_nib} + {4'b0000, carry_q};
    // Sum of the low three bits only; its bit 3 is the carry into bit 3,
    // needed for the overflow flag on the most-significant slice.
    low4     = {1'b0, x_nib[2:0]} + {1'b0, y_nib[2:0]} + {3'b000, carry_q};
    c_into_3 = low4[3];
    c_out    = sum5[4];
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    xa_d        = xa_q;
    yb_d        = yb_q;
    msb_d       = msb_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    set_d       = set_q;
    overflow_d  = overflow_q;
`ifdef SLT_UNSIGNED_EN
    uns_d       = uns_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Store ~y so the slice only ever adds; the +1 enters as carry-in.
          xa_d    = x;
          yb_d    = ~y;
          carry_d = 1'b1;
          idx_d   = '0;
          state_d = S_RUN;
`ifdef SLT_UNSIGNED_EN
          uns_d   = uns;
`endif
        end
      end

      S_RUN: begin
        carry_d = c_out;
        if (idx_q == LAST_IDX) begin
          // idx stays at the last slice; it is only cleared on accept.
          msb_d   = sum5[3];
          ovf_d   = c_into_3 ^ c_out;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        if (!out_valid_q) begin
          // First DONE cycle: publish the result. carry_q now holds the
          // final carry-out of the whole subtraction.
          out_valid_d = 1'b1;
`ifdef SLT_UNSIGNED_EN
          if (uns_q) begin
            set_d      = ~carry_q;
            overflow_d = 1'b0;
          end else begin
            set_d      = msb_q ^ ovf_q;
            overflow_d = ovf_q;
          end
`else
          set_d      = msb_q ^ ovf_q;
          overflow_d = ovf_q;
`endif
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          set_d       = 1'b0;
          overflow_d  = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      xa_q        <= '0;
      yb_q        <= '0;
      msb_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      set_q       <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef SLT_UNSIGNED_EN
      uns_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      xa_q        <= xa_d;
      yb_q        <= yb_d;
      msb_q       <= msb_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      set_q       <= set_d;
      overflow_q  <= overflow_d;
`ifdef SLT_UNSIGNED_EN
      uns_q       <= uns_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all derived directly from flops
  // --------------------------------------------------------------------------
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign set       = set_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_slt_serial_cmp.sv
`default_nettype none
// ============================================================================
// Module      : tb_slt_serial_cmp
// Description : Self-checking bench for slt_serial_cmp (WIDTH=32). Expected
//               results come from plain integer arithmetic on the operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slt_serial_cmp;

  localparam int WIDTH   = 32;
  localparam int LATENCY = WIDTH / 4 + 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic             set;
  logic             overflow;
  logic             busy;
`ifdef SLT_UNSIGNED_EN
  logic             uns;
`endif

  int checks;
  int errors;

  slt_serial_cmp #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .set       (set),
    .overflow  (overflow),
    .busy      (busy)
`ifdef SLT_UNSIGNED_EN
    ,
    .uns       (uns)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference: true difference in 64-bit arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input bit u, output bit s, output bit o);
    longint d;
    if (u) begin
      s = (a < b);
      o = 1'b0;
    end else begin
      d = longint'($signed(a)) - longint'($signed(b));
      s = (d < 0);
      o = (d > 64'sd2147483647) || (d < -64'sd2147483648);
    end
  endfunction

  // Waits for out_valid after an accept; returns edges counted since accept.
  task automatic wait_result(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // One full transaction from IDLE, checked against the model.
  task automatic run_compare(input logic [31:0] a, input logic [31:0] b,
                             input bit u, input int hold);
    bit es, eo;
    int cyc;
    model(a, b, u, es, eo);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL idle_in_ready: got %b expected 1", in_ready);
    end
    x = a; y = b; in_valid = 1'b1;
`ifdef SLT_UNSIGNED_EN
    uns = u;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = $urandom; y = $urandom;
    wait_result(cyc);
    checks++;
    if (cyc !== LATENCY) begin
      errors++; $display("FAIL latency a=%h b=%h: got %0d expected %0d", a, b, cyc, LATENCY);
    end
    checks++;
    if (set !== es || overflow !== eo) begin
      errors++;
      $display("FAIL result a=%h b=%h u=%0d: got set=%b ovf=%b expected set=%b ovf=%b",
               a, b, u, set, overflow, es, eo);
    end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL done_flags: got busy=%b in_ready=%b expected 1/0", busy, in_ready);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || set !== es || overflow !== eo || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable cycle %0d: got v=%b set=%b ovf=%b rdy=%b expected 1 %b %b 0",
                 i, out_valid, set, overflow, in_ready, es, eo);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release: got v=%b rdy=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
`ifdef SLT_UNSIGNED_EN
    uns = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || set !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got v=%b set=%b ovf=%b busy=%b rdy=%b expected 0 0 0 0 1",
               out_valid, set, overflow, busy, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle: got busy=%b rdy=%b expected 0 1", busy, in_ready);
    end
  endtask

  task automatic test_directed();
    run_compare(32'h0000_0001, 32'h0000_0007, 1'b0, 0);
    run_compare(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    run_compare(32'h8000_0000, 32'h0000_0001, 1'b0, 1);
    run_compare(32'h0000_0000, 32'h8000_0000, 1'b0, 0);
    run_compare(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0);
  endtask

  task automatic test_hold();
    run_compare(32'h1234_5678, 32'h1234_5678, 1'b0, 5);
  endtask

  task automatic test_reset_mid_run();
    x = 32'h8000_0000; y = 32'h0000_0001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || set !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got v=%b busy=%b rdy=%b set=%b ovf=%b expected 0 0 1 0 0",
               out_valid, busy, in_ready, set, overflow);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_compare(32'd5, 32'd3, 1'b0, 0);
  endtask

  // in_valid ignored while busy and on the DONE->IDLE handshake edge.
  task automatic test_back_to_back();
    logic [31:0] a, b, c, d;
    bit es, eo;
    int cyc;
    a = 32'hFFFF_FFF0; b = 32'h0000_0010;
    c = 32'h7FFF_0000; d = 32'h8000_0001;
    x = a; y = b; in_valid = 1'b1;
    @(posedge clk); #1;
    x = c; y = d;   // held valid throughout RUN/DONE
    wait_result(cyc);
    model(a, b, 1'b0, es, eo);
    checks++;
    if (set !== es || overflow !== eo) begin
      errors++;
      $display("FAIL b2b_first: got set=%b ovf=%b expected %b %b", set, overflow, es, eo);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_no_accept_in_done: got busy=%b rdy=%b expected 0 1", busy, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept_in_idle: got busy=%b expected 1", busy);
    end
    wait_result(cyc);
    model(c, d, 1'b0, es, eo);
    checks++;
    if (cyc !== LATENCY || set !== es || overflow !== eo) begin
      errors++;
      $display("FAIL b2b_second: got cyc=%0d set=%b ovf=%b expected %0d %b %b",
               cyc, set, overflow, LATENCY, es, eo);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] pool [5];
    logic [31:0] a, b;
    pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0001; pool[2] = 32'h7FFF_FFFF;
    pool[3] = 32'h8000_0000; pool[4] = 32'hFFFF_FFFF;
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) a = pool[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) b = pool[$urandom_range(0, 4)];
      if ($urandom_range(0, 7) == 0) b = a;
      run_compare(a, b, 1'b0, int'($urandom_range(0, 2)));
    end
  endtask

`ifdef SLT_UNSIGNED_EN
  task automatic test_unsigned();
    run_compare(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 0);
    run_compare(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      run_compare($urandom, $urandom, 1'b1, 0);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
`ifdef SLT_UNSIGNED_EN
    test_unsigned();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
